// File: rtl/mem_port_arbiter_if.sv
// Signal bundle joining the fetch requester, the M-stage data requester,
// the port arbiter and the shared word-wide memory port.
interface mem_port_arbiter_if;
    logic        ireq;
    logic [29:0] iaddr;
    logic [31:0] irdata;
    logic        iack;
    logic        ierr;

    logic        dreq;
    logic [29:0] daddr;
    logic [3:0]  dwstb;
    logic [31:0] dwdata;
    logic [31:0] drdata;
    logic        dack;
    logic        derr;

    logic        mreq;
    logic [29:0] maddr;
    logic [3:0]  mwstb;
    logic [31:0] mdatao;
    logic [31:0] mdatai;
    logic        mack;

    // The arbiter is the master of the memory port and answers both requesters.
    modport master (
        input  ireq, iaddr, dreq, daddr, dwstb, dwdata, mdatai, mack,
        output irdata, iack, ierr, drdata, dack, derr, mreq, maddr, mwstb, mdatao
    );

    // Requesters plus memory, seen from the outside of the arbiter.
    modport slave (
        output ireq, iaddr, dreq, daddr, dwstb, dwdata, mdatai, mack,
        input  irdata, iack, ierr, drdata, dack, derr, mreq, maddr, mwstb, mdatao
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and data (D): D-priority with a streak
// limit protecting I, one outstanding access, variable latency with timeout abort.
module mem_port_arbiter #(
    parameter int STREAK_MAX = 4,
    parameter int TIMEOUT    = 255,
    parameter int TO_W       = 8
) (
    input logic                clk,
    input logic                rst_n,
    mem_port_arbiter_if.master ifc
);
    localparam int              SW         = $clog2(STREAK_MAX + 1);
    localparam logic [SW-1:0]   STREAK_LIM = SW'(STREAK_MAX);
    localparam bit              TO_EN      = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            mreq_q, mreq_d;
    logic [29:0]     maddr_q, maddr_d;
    logic [3:0]      mwstb_q, mwstb_d;
    logic [31:0]     mdatao_q, mdatao_d;
    logic [31:0]     irdata_q, irdata_d;
    logic [31:0]     drdata_q, drdata_d;
    logic            iack_q, iack_d;
    logic            ierr_q, ierr_d;
    logic            dack_q, dack_d;
    logic            derr_q, derr_d;
    logic            i_elig, d_elig;

    always_comb begin
        // A request still held while its own completion pulse is visible is not new.
        i_elig   = ifc.ireq & ~iack_q & ~ierr_q;
        d_elig   = ifc.dreq & ~dack_q & ~derr_q;
        state_d  = state_q;
        streak_d = streak_q;
        to_cnt_d = to_cnt_q;
        mreq_d   = mreq_q;
        maddr_d  = maddr_q;
        mwstb_d  = mwstb_q;
        mdatao_d = mdatao_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        iack_d   = 1'b0;
        ierr_d   = 1'b0;
        dack_d   = 1'b0;
        derr_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_elig && (!i_elig || streak_q < STREAK_LIM)) begin
                    state_d  = BUSY_D;
                    mreq_d   = 1'b1;
                    maddr_d  = ifc.daddr;
                    mwstb_d  = ifc.dwstb;
                    mdatao_d = ifc.dwdata;
                    to_cnt_d = '0;
                    if (!i_elig) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_LIM) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else if (i_elig) begin
                    state_d  = BUSY_I;
                    mreq_d   = 1'b1;
                    maddr_d  = ifc.iaddr;
                    mwstb_d  = '0;
                    mdatao_d = '0;
                    to_cnt_d = '0;
                    streak_d = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                // A completion arriving in the last allowed cycle beats the abort.
                if (ifc.mack) begin
                    mreq_d  = 1'b0;
                    state_d = IDLE;
                    if (state_q == BUSY_I) begin
                        iack_d   = 1'b1;
                        irdata_d = ifc.mdatai;
                    end else begin
                        dack_d   = 1'b1;
                        drdata_d = ifc.mdatai;
                    end
                end else if (TO_EN && to_cnt_q == TO_LAST) begin
                    mreq_d  = 1'b0;
                    state_d = IDLE;
                    if (state_q == BUSY_I) begin
                        ierr_d = 1'b1;
                    end else begin
                        derr_d = 1'b1;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            streak_q <= '0;
            to_cnt_q <= '0;
            mreq_q   <= 1'b0;
            maddr_q  <= '0;
            mwstb_q  <= '0;
            mdatao_q <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
            iack_q   <= 1'b0;
            ierr_q   <= 1'b0;
            dack_q   <= 1'b0;
            derr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            to_cnt_q <= to_cnt_d;
            mreq_q   <= mreq_d;
            maddr_q  <= maddr_d;
            mwstb_q  <= mwstb_d;
            mdatao_q <= mdatao_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
            iack_q   <= iack_d;
            ierr_q   <= ierr_d;
            dack_q   <= dack_d;
            derr_q   <= derr_d;
        end
    end

    assign ifc.mreq   = mreq_q;
    assign ifc.maddr  = maddr_q;
    assign ifc.mwstb  = mwstb_q;
    assign ifc.mdatao = mdatao_q;
    assign ifc.irdata = irdata_q;
    assign ifc.drdata = drdata_q;
    assign ifc.iack   = iack_q;
    assign ifc.ierr   = ierr_q;
    assign ifc.dack   = dack_q;
    assign ifc.derr   = derr_q;

    // Requesters must keep address/data steady from raising a request until its completion.
    a_i_hold: assert property (@(posedge clk) disable iff (!rst_n)
        ($past(ifc.ireq) && !$past(iack_q) && !$past(ierr_q) && ifc.ireq && !iack_q && !ierr_q)
        |-> (ifc.iaddr == $past(ifc.iaddr)));

    a_d_hold: assert property (@(posedge clk) disable iff (!rst_n)
        ($past(ifc.dreq) && !$past(dack_q) && !$past(derr_q) && ifc.dreq && !dack_q && !derr_q)
        |-> (ifc.daddr == $past(ifc.daddr) && ifc.dwstb == $past(ifc.dwstb)
             && ifc.dwdata == $past(ifc.dwdata)));

    a_one_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({iack_q, ierr_q, dack_q, derr_q}));
endmodule
